cell_loader: RTL and testbench
==============================

CELL_LOADER -- requirements
Module: cell_loader

Interface
REQ-001 SHALL have parameters (name, default, meaning): WIDTH 20 grid columns; HEIGHT 15 grid rows; B_WIDTH 5 column index width; B_HEIGHT 4 row index width; B_VGA 4 bits per colour channel; B_S_WIDTH 10 hcount width; B_S_HEIGHT 10 vcount width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- vclock  in  1  sole clock.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- hcount  in  B_S_WIDTH  pixel column from the VGA timing generator.
- vcount  in  B_S_HEIGHT  pixel row from the VGA timing generator.
- wr_en  in  1  host cell write strobe.
- wr_x  in  B_WIDTH  write column.
- wr_y  in  B_HEIGHT  write row.
- wr_rgb  in  3*B_VGA  write colour, {r,g,b}.
- swap  in  1  one-cycle request to exchange the front and back banks.
- bg_in  in  3*B_VGA  host background colour.
- cell_rgb  out  3*B_VGA  colour to the matrix display.
- cell_x  out  B_WIDTH  column to the matrix display.
- cell_y  out  B_HEIGHT  row to the matrix display.
- cell_en  out  1  cell write pulse to the matrix display.
- update  out  1  frame-update pulse to the matrix display.
- background  out  3*B_VGA  background colour to the matrix display.
- busy  out  1  streaming in progress.
- overrun  out  1  sticky flag: a stream was restarted before it finished.
- frame_count  out  8  frame counter.

Function
REQ-003 SHALL hold two banks of WIDTH*HEIGHT 12-bit cells, addressed by y*WIDTH+x, with a 1-cycle synchronous read; banks are not reset.
REQ-004 SHALL write wr_rgb to the back bank when wr_en=1 at a rising edge with wr_x<WIDTH and wr_y<HEIGHT. Out-of-range writes SHALL be ignored.
REQ-005 SHALL set a pending-swap flag when swap=1 at an edge.
REQ-006 The frame-start edge is any edge that samples hcount==0 and vcount==0 (edge 0). At edge 0 the block SHALL:
- toggle the bank select if the pending flag or swap is 1, then clear the pending flag;
- latch bg_in into background;
- increment frame_count modulo 256;
- set update=1 and busy=1;
- load x=y=0;
- enter state FETCH.
REQ-007 A write and a swap in the same cycle SHALL target the pre-swap back bank.
REQ-008 The FSM SHALL have states IDLE, FETCH and EMIT:
- IDLE: wait for a frame start.
- FETCH: read the front bank at (x,y), then go to EMIT.
- EMIT: register cell_rgb, cell_x and cell_y, set cell_en=1, and advance x (wrap to 0 with y+1 at x==WIDTH-1). Go to FETCH, or to IDLE after cell (WIDTH-1, HEIGHT-1).
REQ-009 update SHALL be high only during the cycle after edge 0.
REQ-010 cell_en SHALL be high only during the cycles after edges 2, 4, …, 2*WIDTH*HEIGHT. While cell_en is high, cell_x, cell_y and cell_rgb SHALL be stable. Those outputs SHALL hold their values between pulses.
REQ-011 Cells SHALL be emitted in raster order, (0,0) through (WIDTH-1, HEIGHT-1), exactly once per frame.
REQ-012 busy SHALL fall at edge 2*WIDTH*HEIGHT+1 (edge 601 with defaults), together with cell_en.
REQ-013 A frame start while busy=1 SHALL restart at (0,0) with a new update pulse and SHALL set overrun=1. overrun stays 1 until reset.
REQ-014 Host writes and swap requests SHALL never alter the bank being streamed mid-frame.

Reset
REQ-015 Asserting reset (0) SHALL immediately, without a clock edge, force:
- cell_rgb, cell_x, cell_y, cell_en, update, busy, overrun, frame_count to 0;
- background to 0;
- state IDLE, bank select 0 (front = bank 0), pending flag 0.
REQ-016 After reset deasserts mid-stream, no cell_en SHALL occur until the next frame start.

Verification
REQ-017 Assert reset, no clock -> all outputs 0; release, run 1000 cycles with hcount/vcount nonzero -> cell_en never 1.
REQ-018 Write (3,2)=12'hA5C, pulse swap, then frame start -> results:
- update high 1 cycle;
- 300 cell_en pulses, period 2;
- pulse 44 has x=3, y=2, rgb=A5C;
- last pulse has x=19, y=14;
- busy falls at edge 601;
- frame_count=1.
REQ-019 Write (5,5)=12'h123 with no swap, then frame start -> pulse 106 still shows the prior front-bank value. Swap, then next frame start -> 12'h123.
REQ-020 Write x=20, y=0 to 12'hFFF; swap; frame start -> no emitted cell is changed and no out-of-range address is written.
REQ-021 Force hcount=vcount=0 at pulse 100 -> restart at (0,0) with update=1 and overrun=1; the full 300 pulses follow.
REQ-022 Assert reset at pulse 50 -> outputs 0 asynchronously. Release -> idle until frame start, then a full normal stream with frame_count=1.

Source files
------------

// File: rtl/cell_loader.sv
// cell_loader: double-buffered cell store, streamed in raster order to a matrix display once per video frame.
// Latency: update one cycle after frame start; then one cell_en every 2 cycles; busy drops at edge 2*WIDTH*HEIGHT+1.
// Backpressure: none; the display must take a cell every other cycle; a new frame start always restarts the stream.
// Ports: vclock/reset (async, active-low); hcount/vcount mark frame start at (0,0);
//        wr_en/wr_x/wr_y/wr_rgb write the back bank, swap requests a bank exchange at the next frame start;
//        cell_rgb/cell_x/cell_y/cell_en, update, background drive the display; busy, overrun, frame_count report status.
module cell_loader #(
    parameter int WIDTH      = 20,
    parameter int HEIGHT     = 15,
    parameter int B_WIDTH    = 5,
    parameter int B_HEIGHT   = 4,
    parameter int B_VGA      = 4,
    parameter int B_S_WIDTH  = 10,
    parameter int B_S_HEIGHT = 10
) (
    input  logic                    vclock,
    input  logic                    reset,
    input  logic [B_S_WIDTH-1:0]    hcount,
    input  logic [B_S_HEIGHT-1:0]   vcount,
    input  logic                    wr_en,
    input  logic [B_WIDTH-1:0]      wr_x,
    input  logic [B_HEIGHT-1:0]     wr_y,
    input  logic [3*B_VGA-1:0]      wr_rgb,
    input  logic                    swap,
    input  logic [3*B_VGA-1:0]      bg_in,
    output logic [3*B_VGA-1:0]      cell_rgb,
    output logic [B_WIDTH-1:0]      cell_x,
    output logic [B_HEIGHT-1:0]     cell_y,
    output logic                    cell_en,
    output logic                    update,
    output logic [3*B_VGA-1:0]      background,
    output logic                    busy,
    output logic                    overrun,
    output logic [7:0]              frame_count
);

    localparam int N_CELLS = WIDTH * HEIGHT;
    localparam int B_ADDR  = $clog2(N_CELLS);
    localparam int B_RGB   = 3 * B_VGA;
    localparam logic [B_WIDTH-1:0]  X_LAST = B_WIDTH'(WIDTH - 1);
    localparam logic [B_HEIGHT-1:0] Y_LAST = B_HEIGHT'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   bank_sel_q;     // front bank index; back bank is the other one
    logic                   pend_q;         // swap requested, applied at the next frame start
    logic [B_WIDTH-1:0]     x_q, x_d;
    logic [B_HEIGHT-1:0]    y_q, y_d;
    logic [B_RGB-1:0]       rd_q;           // front-bank read data, valid in EMIT
    logic [B_RGB-1:0]       cell_rgb_q;
    logic [B_WIDTH-1:0]     cell_x_q;
    logic [B_HEIGHT-1:0]    cell_y_q;
    logic                   cell_en_q;
    logic                   update_q;
    logic [B_RGB-1:0]       bg_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic [7:0]             frame_q;

    // Cell storage is intentionally not reset.
    logic [B_RGB-1:0]       bank0_q [N_CELLS];
    logic [B_RGB-1:0]       bank1_q [N_CELLS];

    logic                   frame_start;
    logic                   wr_ok;
    logic                   last_cell;
    logic [B_ADDR-1:0]      wr_addr;
    logic [B_ADDR-1:0]      rd_addr;

    assign frame_start = (hcount == '0) && (vcount == '0);
    assign wr_ok       = wr_en && (wr_x <= X_LAST) && (wr_y <= Y_LAST);
    assign wr_addr     = B_ADDR'(wr_y) * B_ADDR'(WIDTH) + B_ADDR'(wr_x);
    assign rd_addr     = B_ADDR'(y_q) * B_ADDR'(WIDTH) + B_ADDR'(x_q);
    assign last_cell   = (x_q == X_LAST) && (y_q == Y_LAST);

    // Raster advance: wrap the column and step the row.
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
        end
    end

    // Host writes always land in the back bank as selected before any swap
    // taking effect on this same edge; streaming reads only the front bank.
    always_ff @(posedge vclock) begin
        if (wr_ok) begin
            if (bank_sel_q) begin
                bank0_q[wr_addr] <= wr_rgb;
            end else begin
                bank1_q[wr_addr] <= wr_rgb;
            end
        end
        if (state_q == FETCH) begin
            rd_q <= bank_sel_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
        end
    end

    always_ff @(posedge vclock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bank_sel_q <= 1'b0;
            pend_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            cell_rgb_q <= '0;
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            cell_en_q  <= 1'b0;
            update_q   <= 1'b0;
            bg_q       <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            frame_q    <= 8'd0;
        end else begin
            update_q <= 1'b0;
            if (swap) begin
                pend_q <= 1'b1;
            end
            if (frame_start) begin
                // A swap on the frame-start edge itself counts as pending.
                if (pend_q || swap) begin
                    bank_sel_q <= ~bank_sel_q;
                end
                pend_q    <= 1'b0;
                bg_q      <= bg_in;
                frame_q   <= frame_q + 8'd1;
                update_q  <= 1'b1;
                busy_q    <= 1'b1;
                cell_en_q <= 1'b0;
                if (busy_q) begin
                    overrun_q <= 1'b1;
                end
                x_q     <= '0;
                y_q     <= '0;
                state_q <= FETCH;
            end else begin
                case (state_q)
                    IDLE: begin
                        cell_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                    FETCH: begin
                        cell_en_q <= 1'b0;
                        state_q   <= EMIT;
                    end
                    EMIT: begin
                        cell_rgb_q <= rd_q;
                        cell_x_q   <= x_q;
                        cell_y_q   <= y_q;
                        cell_en_q  <= 1'b1;
                        x_q        <= x_d;
                        y_q        <= y_d;
                        state_q    <= last_cell ? IDLE : FETCH;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cell_rgb    = cell_rgb_q;
    assign cell_x      = cell_x_q;
    assign cell_y      = cell_y_q;
    assign cell_en     = cell_en_q;
    assign update      = update_q;
    assign background  = bg_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_cell_loader.sv
// tb_cell_loader: self-checking bench for cell_loader.
// Latency: checks every cycle of each frame against a cell-level reference model.
// Backpressure: none in the design; the bench only drives host writes, swaps and frame starts.
module tb_cell_loader;

    localparam int W = 20;
    localparam int H = 15;
    localparam int N = W * H;

    logic        vclock = 1'b0;
    logic        reset  = 1'b1;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        wr_en;
    logic [4:0]  wr_x;
    logic [3:0]  wr_y;
    logic [11:0] wr_rgb;
    logic        swap;
    logic [11:0] bg_in;
    logic [11:0] cell_rgb;
    logic [4:0]  cell_x;
    logic [3:0]  cell_y;
    logic        cell_en;
    logic        update;
    logic [11:0] background;
    logic        busy;
    logic        overrun;
    logic [7:0]  frame_count;

    cell_loader dut (
        .vclock      (vclock),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_rgb      (wr_rgb),
        .swap        (swap),
        .bg_in       (bg_in),
        .cell_rgb    (cell_rgb),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .cell_en     (cell_en),
        .update      (update),
        .background  (background),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 vclock = ~vclock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    endtask

    // Reference model: two banks of cells, a front index, a pending swap,
    // and the display-side values the stream should leave behind.
    logic [11:0] mbank [2][N];
    int          mfront = 0;
    bit          mpend  = 0;
    bit          mbusy  = 0;
    bit          movr   = 0;
    int          mframes = 0;
    logic [11:0] mbg    = 12'h0;
    logic [11:0] mh_rgb = 12'h0;
    int          mh_x   = 0;
    int          mh_y   = 0;

    logic [11:0] got_rgb [N];
    int          got_x [N];
    int          got_y [N];

    function automatic void m_reset();
        mfront = 0; mpend = 0; mbusy = 0; movr = 0; mframes = 0;
        mbg = 12'h0; mh_rgb = 12'h0; mh_x = 0; mh_y = 0;
    endfunction

    task automatic tick();
        @(posedge vclock);
        #1;
    endtask

    // Inputs set here are sampled at the next rising edge; the model is updated now.
    task automatic drive_host(input bit en, input int x, input int y, input logic [11:0] c, input bit sw);
        wr_en  = en;
        wr_x   = 5'(x);
        wr_y   = 4'(y);
        wr_rgb = c;
        swap   = sw;
        if (en && x < W && y < H) mbank[1 - mfront][y * W + x] = c;
        if (sw) mpend = 1;
    endtask

    task automatic idle_host();
        wr_en  = 1'b0;
        swap   = 1'b0;
        hcount = 10'($urandom_range(1, 799));
        vcount = 10'($urandom_range(0, 524));
    endtask

    task automatic frame_start(input bit en, input int x, input int y, input logic [11:0] c, input bit sw);
        drive_host(en, x, y, c, sw);
        hcount = 10'd0;
        vcount = 10'd0;
        bg_in  = 12'($urandom);
        if (mbusy) movr = 1;
        if (mpend) mfront = 1 - mfront;
        mpend   = 0;
        mframes = (mframes + 1) % 256;
        mbg     = bg_in;
        mbusy   = 1;
        tick();
        idle_host();
    endtask

    // Called in the cycle right after the frame-start edge. Checks every
    // output each cycle; stop_pulse>0 returns right after that pulse is seen.
    task automatic stream(input int stop_pulse, input bit rnd, output int np);
        np = 0;
        for (int k = 0; k <= 601; k++) begin
            bit en_exp;
            int p;
            en_exp = (k >= 2) && (k % 2 == 0) && (k <= 600);
            p = k / 2;
            if (en_exp) begin
                mh_x   = (p - 1) % W;
                mh_y   = (p - 1) / W;
                mh_rgb = mbank[mfront][p - 1];
            end
            chk("update",      k, 32'(update),      32'(k == 0));
            chk("cell_en",     k, 32'(cell_en),     32'(en_exp));
            chk("busy",        k, 32'(busy),        32'(k <= 600));
            chk("cell_x",      k, 32'(cell_x),      32'(mh_x));
            chk("cell_y",      k, 32'(cell_y),      32'(mh_y));
            chk("cell_rgb",    k, 32'(cell_rgb),    32'(mh_rgb));
            chk("overrun",     k, 32'(overrun),     32'(movr));
            chk("frame_count", k, 32'(frame_count), 32'(mframes));
            chk("background",  k, 32'(background),  32'(mbg));
            if (cell_en) begin
                if (np < N) begin
                    got_rgb[np] = cell_rgb;
                    got_x[np]   = int'(cell_x);
                    got_y[np]   = int'(cell_y);
                end
                np++;
            end
            if (stop_pulse > 0 && en_exp && p == stop_pulse) return;
            if (rnd) begin
                drive_host($urandom_range(0, 9) < 4, $urandom_range(0, 23), $urandom_range(0, 15),
                           12'($urandom), $urandom_range(0, 39) == 0);
                hcount = 10'($urandom_range(1, 799));
                vcount = 10'($urandom_range(0, 524));
                bg_in  = 12'($urandom);
            end else begin
                idle_host();
            end
            tick();
        end
        idle_host();
        mbusy = 0;
        chk("pulse_count", 0, 32'(np), 32'(N));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cell_rgb"},    0, 32'(cell_rgb),    0);
        chk({tag, "_cell_x"},      0, 32'(cell_x),      0);
        chk({tag, "_cell_y"},      0, 32'(cell_y),      0);
        chk({tag, "_cell_en"},     0, 32'(cell_en),     0);
        chk({tag, "_update"},      0, 32'(update),      0);
        chk({tag, "_busy"},        0, 32'(busy),        0);
        chk({tag, "_overrun"},     0, 32'(overrun),     0);
        chk({tag, "_frame_count"}, 0, 32'(frame_count), 0);
        chk({tag, "_background"},  0, 32'(background),  0);
    endtask

    task automatic fill_back(input logic [11:0] base);
        for (int i = 0; i < N; i++) begin
            drive_host(1, i % W, i / W, base | 12'(i), 0);
            tick();
        end
        drive_host(0, 0, 0, 12'h0, 1);
        tick();
        idle_host();
        tick();
    endtask

    typedef struct {
        bit          en;
        int          x;
        int          y;
        logic [11:0] rgb;
        bit          sw;
        int          probe;   // 1-based pulse number to inspect
        int          ex;
        int          ey;
        logic [11:0] erg;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int np;

        // Bank contents after initialisation: bank1 = 0x400|i, bank0 = 0x800|i, front = bank0.
        tbl[0] = '{1,  3,  2, 12'hA5C, 1,  44,  3,  2, 12'hA5C};
        tbl[1] = '{1,  5,  5, 12'h123, 0, 106,  5,  5, 12'h469};
        tbl[2] = '{0,  0,  0, 12'h000, 1, 106,  5,  5, 12'h123};
        tbl[3] = '{1, 20,  0, 12'hFFF, 1,  21,  0,  1, 12'h414};
        tbl[4] = '{1,  0, 15, 12'hFFF, 0,   1,  0,  0, 12'h400};
        tbl[5] = '{1, 19, 14, 12'hABC, 1, 300, 19, 14, 12'hABC};
        tbl[6] = '{1, 31, 15, 12'hFFF, 1, 300, 19, 14, 12'h52B};

        wr_en = 1'b0; swap = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
        bg_in = 12'h0; hcount = 10'd5; vcount = 10'd5;

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1 check_zero("rst_async");
        tick();
        reset = 1'b1;
        m_reset();

        // No frame start: nothing streams.
        for (int i = 0; i < 1000; i++) begin
            idle_host();
            tick();
            chk("idle_cell_en", i, 32'(cell_en), 0);
            chk("idle_busy",    i, 32'(busy),    0);
        end

        // Load both banks with known contents.
        fill_back(12'h400);
        frame_start(0, 0, 0, 12'h0, 0);
        stream(0, 0, np);
        fill_back(12'h800);
        frame_start(0, 0, 0, 12'h0, 0);
        stream(0, 0, np);

        // Table-driven write/swap vectors, each followed by a full frame.
        for (int v = 0; v < 7; v++) begin
            drive_host(tbl[v].en, tbl[v].x, tbl[v].y, tbl[v].rgb, tbl[v].sw);
            tick();
            idle_host();
            tick();
            frame_start(0, 0, 0, 12'h0, 0);
            stream(0, 0, np);
            chk("tbl_rgb", v, 32'(got_rgb[tbl[v].probe - 1]), 32'(tbl[v].erg));
            chk("tbl_x",   v, 32'(got_x[tbl[v].probe - 1]),   32'(tbl[v].ex));
            chk("tbl_y",   v, 32'(got_y[tbl[v].probe - 1]),   32'(tbl[v].ey));
        end

        // Write and swap on the frame-start edge: write lands in the pre-swap back bank,
        // which becomes the streamed front bank.
        frame_start(1, 0, 0, 12'h5A5, 1);
        stream(0, 0, np);
        chk("edge0_wr_swap", 0, 32'(got_rgb[0]), 32'h5A5);

        // Frame start in the middle of a stream restarts it and sets overrun.
        frame_start(0, 0, 0, 12'h0, 0);
        stream(100, 0, np);
        frame_start(0, 0, 0, 12'h0, 0);
        stream(0, 0, np);
        chk("restart_overrun", 0, 32'(overrun), 1);
        chk("restart_first_x", 0, 32'(got_x[0]), 0);

        // Reset mid-stream: outputs clear without an edge; stream resumes only on frame start.
        frame_start(0, 0, 0, 12'h0, 0);
        stream(50, 0, np);
        reset = 1'b0;
        #1 check_zero("rst_mid");
        m_reset();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            idle_host();
            tick();
            chk("post_rst_cell_en", i, 32'(cell_en), 0);
        end
        frame_start(0, 0, 0, 12'h0, 0);
        stream(0, 0, np);
        chk("post_rst_frames", 0, 32'(frame_count), 1);

        // Randomised host traffic, including mid-frame writes and swaps.
        for (int f = 0; f < 6; f++) begin
            frame_start($urandom_range(0, 1) == 1, $urandom_range(0, 23), $urandom_range(0, 15),
                        12'($urandom), $urandom_range(0, 1) == 1);
            stream(0, 1, np);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
